csa_accumulator: RTL

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator_if.sv | 25 ++
 rtl/csa_accumulator.sv | 121 ++++++++++++
 2 files changed

// File: rtl/csa_accumulator_if.sv
// Beat-in / result-out handshake bundle for csa_accumulator.
// slave = the accumulator, master = the producer/consumer side.
interface csa_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/csa_accumulator.sv
// Carry-save streaming accumulator: sums a burst of unsigned beats and resolves once at the end.
// Optional macro CSA_ACCUMULATOR_SAT_EN saturates the result to all-ones on overflow.
module csa_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    csa_accumulator_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACC     = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0] out_count_q;

    logic             beat_acc;
    logic             result_taken;
    logic [WIDTH-1:0] csa_s;
    logic [WIDTH-1:0] csa_m;
    logic [WIDTH-1:0] resolved;

    // in_ready is gated by rst_n so no beat is offered while reset is held.
    assign bus.in_ready  = rst_n && ((state_q == IDLE) || (state_q == ACC));
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    assign beat_acc     = bus.in_valid && bus.in_ready;
    assign result_taken = bus.out_valid && bus.out_ready;

    // One full-adder row per beat; no carry ripples until RESOLVE.
    assign csa_s = sum_q ^ carry_q ^ bus.in_data;
    assign csa_m = (sum_q & carry_q) | (sum_q & bus.in_data) | (carry_q & bus.in_data);

`ifdef CSA_ACCUMULATOR_SAT_EN
    logic             overflow_q;
    logic [WIDTH:0]   full_sum;

    assign full_sum = {1'b0, sum_q} + {1'b0, carry_q};
    assign resolved = (overflow_q || full_sum[WIDTH]) ? '1 : full_sum[WIDTH-1:0];

    // Sticky: csa_m's MSB is shifted out of carry_q, so it is lost weight 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (result_taken) begin
            overflow_q <= 1'b0;
        end else if ((beat_acc && csa_m[WIDTH-1]) || ((state_q == RESOLVE) && full_sum[WIDTH])) begin
            overflow_q <= 1'b1;
        end
    end
`else
    logic unused_csa_msb;

    assign unused_csa_msb = csa_m[WIDTH-1];
    assign resolved       = sum_q + carry_q;
`endif

    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE, ACC: begin
                if (beat_acc) begin
                    state_d = bus.in_last ? RESOLVE : ACC;
                end
            end
            RESOLVE: state_d = OUT;
            OUT: begin
                if (result_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q <= state_d;

            if (beat_acc) begin
                sum_q   <= csa_s;
                carry_q <= csa_m << 1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end else if (result_taken) begin
                sum_q   <= '0;
                carry_q <= '0;
                cnt_q   <= '0;
            end

            // Result registers only load here, so they hold through any backpressure in OUT.
            if (state_q == RESOLVE) begin
                out_data_q  <= resolved;
                out_count_q <= cnt_q;
            end
        end
    end

endmodule
